// File: rtl/dff_sync_pkg.sv
// Shared defaults for the dff_sync storage cell.
package dff_sync_pkg;

  localparam int unsigned DFF_DEFAULT_WIDTH = 1;

endpackage : dff_sync_pkg

// File: rtl/dff_sync.sv
// D flip-flop register: asynchronous active-high reset, synchronous active-high set.
// Priority rst > set > d; q is driven directly by the flop.
module dff_sync
  import dff_sync_pkg::*;
#(
  parameter int unsigned      WIDTH   = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset is in the sensitivity list, so it overrides any coincident clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (set) begin
      q <= SET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule : dff_sync

// File: tb/tb_dff_sync.sv
// Scoreboard bench for dff_sync: a 1-bit default build and an 8-bit build
// (RST_VAL=8'hA5, SET_VAL=8'h3C) share rst/set and are checked side by side.
module tb_dff_sync;

  typedef struct {
    string      name;
    logic       e1;
    logic [7:0] e8;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       set;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic [7:0] q8;

  int checks = 0;
  int errors = 0;

  exp_t sync_q[$];
  exp_t async_q[$];
  event async_ev;

  dff_sync u_dff1 (
    .clk (clk),
    .rst (rst),
    .set (set),
    .d   (d1),
    .q   (q1)
  );

  dff_sync #(
    .WIDTH   (8),
    .RST_VAL (8'hA5),
    .SET_VAL (8'h3C)
  ) u_dff8 (
    .clk (clk),
    .rst (rst),
    .set (set),
    .d   (d8),
    .q   (q8)
  );

  // Rising edges at 5, 15, 25 ... ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void compare(input exp_t e);
    checks = checks + 2;
    if (q1 !== e.e1) begin
      errors = errors + 1;
      $display("FAIL %s (width1) at %0t: got %b expected %b", e.name, $time, q1, e.e1);
    end
    if (q8 !== e.e8) begin
      errors = errors + 1;
      $display("FAIL %s (width8) at %0t: got %h expected %h", e.name, $time, q8, e.e8);
    end
  endfunction

  // Clocked monitor: one expectation per falling edge, covering the preceding rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sync_q.size() > 0) begin
        e = sync_q.pop_front();
        compare(e);
      end
    end
  end

  // Immediate monitor: mid-cycle checks that require no clock edge.
  initial begin
    exp_t e;
    forever begin
      @(async_ev);
      while (async_q.size() > 0) begin
        e = async_q.pop_front();
        compare(e);
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic dv1, input logic [7:0] dv8);
    rst = r;
    set = s;
    d1  = dv1;
    d8  = dv8;
  endtask

  task automatic expect_sync(input string n, input logic e1, input logic [7:0] e8);
    exp_t e;
    e.name = n;
    e.e1   = e1;
    e.e8   = e8;
    sync_q.push_back(e);
  endtask

  task automatic expect_now(input string n, input logic e1, input logic [7:0] e8);
    exp_t e;
    e.name = n;
    e.e1   = e1;
    e.e8   = e8;
    async_q.push_back(e);
    ->async_ev;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Plain load at the 5 ns edge.
    drive(1'b0, 1'b0, 1'b1, 8'h5A);
    expect_sync("load_d", 1'b1, 8'h5A);
    next_cycle();

    // Reset mid-cycle acts at once, then holds across the next edge.
    drive(1'b0, 1'b0, 1'b1, 8'hC3);
    #2 rst = 1'b1;
    #1 expect_now("async_rst", 1'b0, 8'hA5);
    expect_sync("rst_hold", 1'b0, 8'hA5);
    next_cycle();

    drive(1'b1, 1'b0, 1'b1, 8'hFF);
    expect_sync("rst_ignores_d", 1'b0, 8'hA5);
    next_cycle();

    drive(1'b1, 1'b1, 1'b1, 8'hFF);
    expect_sync("rst_over_set", 1'b0, 8'hA5);
    next_cycle();

    // Release without an edge leaves q at the reset value.
    drive(1'b0, 1'b0, 1'b1, 8'h96);
    #2 expect_now("release_no_edge", 1'b0, 8'hA5);
    expect_sync("after_release", 1'b1, 8'h96);
    next_cycle();

    drive(1'b0, 1'b0, 1'b1, 8'h96);
    expect_sync("hold_d", 1'b1, 8'h96);
    next_cycle();

    drive(1'b0, 1'b0, 1'b0, 8'h00);
    expect_sync("load_zero", 1'b0, 8'h00);
    next_cycle();

    // Set raised between edges has no effect until the next edge.
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    #1 expect_now("set_between_edges", 1'b0, 8'h00);
    expect_sync("set_load", 1'b1, 8'h3C);
    next_cycle();

    drive(1'b0, 1'b1, 1'b0, 8'h11);
    expect_sync("set_over_d", 1'b1, 8'h3C);
    next_cycle();

    drive(1'b0, 1'b0, 1'b0, 8'h11);
    expect_sync("set_release", 1'b0, 8'h11);
    next_cycle();

    // Reset asserted exactly on a rising edge wins over d.
    drive(1'b0, 1'b0, 1'b1, 8'h77);
    @(posedge clk);
    rst = 1'b1;
    expect_sync("rst_at_edge", 1'b0, 8'hA5);
    next_cycle();

    drive(1'b0, 1'b0, 1'b0, 8'hE7);
    expect_sync("recover", 1'b0, 8'hE7);
    next_cycle();

    drive(1'b0, 1'b0, 1'b1, 8'h81);
    expect_sync("recover_load", 1'b1, 8'h81);
    next_cycle();

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 4; i++) begin
      if (sync_q.size() == 0 && async_q.size() == 0) break;
      @(negedge clk);
    end
    #1;
    if (sync_q.size() != 0 || async_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d entries pending expected 0", sync_q.size() + async_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dff_sync
